// File: rtl/id_stage_pipe.sv
// Decode stage: register file with write-through bypass, hazard detection, ID-stage
// branch/jump resolution and the ID/EX pipeline register. Optional macro BRANCH_FWD_EN.
module id_stage_pipe #(
    parameter int XLEN     = 32,
    parameter int RADDR_W  = 5,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [31:0]        if_instr,
    input  logic [XLEN-1:0]    if_pc4,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               ex_hold,
    input  logic               mem_reg_write,
    input  logic               mem_is_load,
    input  logic [RADDR_W-1:0] mem_dst,
    input  logic [XLEN-1:0]    mem_result,
    output logic               stall,
    output logic               flush_if,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc4,
    output logic [XLEN-1:0]    ex_rs_data,
    output logic [XLEN-1:0]    ex_rt_data,
    output logic [XLEN-1:0]    ex_imm,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_dst,
    output logic [2:0]         ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_reg_write,
    output logic [1:0]         ex_mem_to_reg,
    output logic               ex_illegal
);
    localparam int NREG = 1 << RADDR_W;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc4;
        logic [XLEN-1:0]    rs_data;
        logic [XLEN-1:0]    rt_data;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rs;
        logic [RADDR_W-1:0] rt;
        logic [RADDR_W-1:0] dst;
        logic [2:0]         alu_op;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic [1:0]         mem_to_reg;
        logic               illegal;
    } idex_t;

    logic [XLEN-1:0]    regs [NREG];
    idex_t              idex_q, idex_d, dec;

    logic [5:0]         opc, funct;
    logic [RADDR_W-1:0] rs_a, rt_a, rd_a;
    logic [XLEN-1:0]    imm_sx, rs_val, rt_val, cmp_rs, cmp_rt;
    logic               is_beq, is_bne, is_j, is_jal, legal, uses_rs, uses_rt;
    logic               is_br, load_use, br_ex, br_mem, mem_match, mem_blocks;
    logic               hazard, accept, taken;

    assign opc    = if_instr[31:26];
    assign funct  = if_instr[5:0];
    assign rs_a   = if_instr[25:21];
    assign rt_a   = if_instr[20:16];
    assign rd_a   = if_instr[15:11];
    assign imm_sx = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_we && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Write-through: a same-cycle writeback is visible to this decode.
    assign rs_val = (rs_a == '0) ? '0 : (wb_we && wb_addr == rs_a) ? wb_data : regs[rs_a];
    assign rt_val = (rt_a == '0) ? '0 : (wb_we && wb_addr == rt_a) ? wb_data : regs[rt_a];

    always_comb begin
        dec         = '0;
        dec.valid   = 1'b1;
        dec.pc4     = if_pc4;
        dec.rs_data = rs_val;
        dec.rt_data = rt_val;
        dec.imm     = imm_sx;
        dec.rs      = rs_a;
        dec.rt      = rt_a;
        is_beq      = 1'b0;
        is_bne      = 1'b0;
        is_j        = 1'b0;
        is_jal      = 1'b0;
        legal       = 1'b1;
        case (opc)
            OP_R: begin
                dec.reg_write = 1'b1;
                dec.dst       = rd_a;
                case (funct)
                    6'b100000: dec.alu_op = ALU_ADD;
                    6'b100010: dec.alu_op = ALU_SUB;
                    6'b100100: dec.alu_op = ALU_AND;
                    6'b100101: dec.alu_op = ALU_OR;
                    6'b101010: dec.alu_op = ALU_SLT;
                    default:   legal = 1'b0;
                endcase
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 2'b01;
                dec.dst        = rt_a;
            end
            OP_SW: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.dst       = rt_a;
            end
            OP_ADDI: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.dst       = rt_a;
            end
            OP_SLTI: begin
                dec.alu_op    = ALU_SLT;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.dst       = rt_a;
            end
            OP_BEQ: is_beq = 1'b1;
            OP_BNE: is_bne = 1'b1;
            OP_J:   is_j   = 1'b1;
            OP_JAL: begin
                is_jal         = 1'b1;
                dec.reg_write  = 1'b1;
                dec.dst        = RADDR_W'(LINK_REG);
                dec.mem_to_reg = 2'b10;
            end
            default: legal = 1'b0;
        endcase
    end

    assign uses_rs = !(is_j || is_jal);
    assign uses_rt = (opc == OP_R) || (opc == OP_SW) || is_beq || is_bne;
    assign is_br   = is_beq || is_bne;

`ifdef BRANCH_FWD_EN
    // Only a non-load MEM result is ready early enough to feed the comparator.
    assign mem_blocks = mem_is_load;
    assign cmp_rs = (mem_reg_write && !mem_is_load && mem_dst != '0 && mem_dst == rs_a) ? mem_result : rs_val;
    assign cmp_rt = (mem_reg_write && !mem_is_load && mem_dst != '0 && mem_dst == rt_a) ? mem_result : rt_val;
`else
    logic [XLEN:0] unused_mem;
    assign unused_mem = {mem_is_load, mem_result};
    assign mem_blocks = 1'b1;
    assign cmp_rs     = rs_val;
    assign cmp_rt     = rt_val;
`endif

    assign load_use  = idex_q.valid && idex_q.mem_read && idex_q.dst != '0 &&
                       ((uses_rs && idex_q.dst == rs_a) || (uses_rt && idex_q.dst == rt_a));
    assign br_ex     = is_br && idex_q.reg_write && idex_q.dst != '0 &&
                       (idex_q.dst == rs_a || idex_q.dst == rt_a);
    assign mem_match = mem_reg_write && mem_dst != '0 && (mem_dst == rs_a || mem_dst == rt_a);
    assign br_mem    = is_br && mem_match && mem_blocks;
    assign hazard    = load_use || br_ex || br_mem;

    assign stall    = (if_valid && hazard) || ex_hold;
    assign accept   = if_valid && !stall;
    assign taken    = (is_beq && cmp_rs == cmp_rt) || (is_bne && cmp_rs != cmp_rt) || is_j || is_jal;
    assign redirect = accept && taken;
    assign flush_if = redirect;
    assign redirect_pc = (is_j || is_jal) ? {if_pc4[XLEN-1:28], if_instr[25:0], 2'b00}
                                          : if_pc4 + (imm_sx << 2);

    always_comb begin
        idex_d = '0;
        if (ex_hold) begin
            idex_d = idex_q;
        end else if (!if_valid || hazard) begin
            idex_d = '0;
        end else if (!legal) begin
            idex_d.illegal = 1'b1;
        end else begin
            idex_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idex_q <= '0;
        else        idex_q <= idex_d;
    end

    assign ex_valid      = idex_q.valid;
    assign ex_pc4        = idex_q.pc4;
    assign ex_rs_data    = idex_q.rs_data;
    assign ex_rt_data    = idex_q.rt_data;
    assign ex_imm        = idex_q.imm;
    assign ex_rs         = idex_q.rs;
    assign ex_rt         = idex_q.rt;
    assign ex_dst        = idex_q.dst;
    assign ex_alu_op     = idex_q.alu_op;
    assign ex_alu_src    = idex_q.alu_src;
    assign ex_mem_read   = idex_q.mem_read;
    assign ex_mem_write  = idex_q.mem_write;
    assign ex_reg_write  = idex_q.reg_write;
    assign ex_mem_to_reg = idex_q.mem_to_reg;
    assign ex_illegal    = idex_q.illegal;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized scoreboard bench for id_stage_pipe; reference model is an
// instruction-class table plus an architectural register array.
module tb_id_stage_pipe;
    localparam int XLEN = 32;
`ifdef BRANCH_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic if_valid = 0, wb_we = 0, ex_hold = 0, mem_reg_write = 0, mem_is_load = 0;
    logic [31:0] if_instr = 0, if_pc4 = 0, wb_data = 0, mem_result = 0;
    logic [4:0]  wb_addr = 0, mem_dst = 0;
    logic stall, flush_if, redirect;
    logic [31:0] redirect_pc, ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_illegal;
    logic [4:0] ex_rs, ex_rt, ex_dst;
    logic [2:0] ex_alu_op;
    logic [1:0] ex_mem_to_reg;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .RADDR_W(5), .LINK_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_hold(ex_hold),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_dst(mem_dst),
        .mem_result(mem_result), .stall(stall), .flush_if(flush_if), .redirect(redirect),
        .redirect_pc(redirect_pc), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_illegal(ex_illegal)
    );

    typedef enum {K_R, K_LW, K_SW, K_ADDI, K_SLTI, K_BEQ, K_BNE, K_J, K_JAL, K_BAD} kind_e;
    typedef struct {
        bit v; logic [31:0] pc4, rsd, rtd, imm; logic [4:0] rs, rt, dst;
        logic [2:0] op; bit src, mr, mw, rw; logic [1:0] m2r; bit ill;
    } st_t;
    typedef struct { bit stall, redirect; logic [31:0] rpc; st_t s; } exp_t;

    exp_t q[$];
    st_t  st;
    logic [31:0] mregs [32];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic st_t zero_st();
        st_t z = '{default: '0};
        return z;
    endfunction

    // Architectural meaning of R-type funct codes; -1 means not part of the ISA.
    function automatic int r_op(input logic [5:0] f);
        case (f)
            6'h20: return 0;  6'h22: return 1;  6'h24: return 2;
            6'h25: return 3;  6'h2a: return 4;  default: return -1;
        endcase
    endfunction

    function automatic kind_e classify(input logic [31:0] ins);
        case (ins[31:26])
            6'd0:  return (r_op(ins[5:0]) < 0) ? K_BAD : K_R;
            6'h23: return K_LW;   6'h2b: return K_SW;
            6'h08: return K_ADDI; 6'h0a: return K_SLTI;
            6'h04: return K_BEQ;  6'h05: return K_BNE;
            6'h02: return K_J;    6'h03: return K_JAL;
            default: return K_BAD;
        endcase
    endfunction

    function automatic logic [31:0] rdv(input logic [4:0] s, input bit we, input logic [4:0] wa,
                                        input logic [31:0] wd);
        if (s == 0) return 0;
        if (we && wa == s) return wd;
        return mregs[s];
    endfunction

    function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input logic [5:0] f);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, f};
    endfunction
    function automatic logic [31:0] mk_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc4,
                        input bit we, input logic [4:0] wa, input logic [31:0] wd, input bit hold,
                        input bit mrw, input bit mld, input logic [4:0] md, input logic [31:0] mres);
        kind_e k; exp_t e; st_t n; logic [4:0] rs, rt, s;
        logic [31:0] off, ca, cb; bit haz, br, urs, urt, jmp, taken;
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc4 = pc4; wb_we = we; wb_addr = wa; wb_data = wd;
        ex_hold = hold; mem_reg_write = mrw; mem_is_load = mld; mem_dst = md; mem_result = mres;
        k = classify(ins);
        rs = ins[25:21]; rt = ins[20:16];
        br  = (k == K_BEQ || k == K_BNE);
        jmp = (k == K_J || k == K_JAL);
        urs = !jmp;
        urt = (ins[31:26] == 0) || k == K_SW || br;
        // A load in EX cannot supply any reader; branches also wait on unresolved producers.
        haz = st.v && st.mr && st.dst != 0 && ((urs && st.dst == rs) || (urt && st.dst == rt));
        if (br) begin
            for (int i = 0; i < 2; i++) begin
                s = (i == 0) ? rs : rt;
                if (s != 0 && st.rw && st.dst == s) haz = 1;
                if (s != 0 && mrw && md == s && (mld || !FWD)) haz = 1;
            end
        end
        ca = (FWD && mrw && !mld && rs != 0 && md == rs) ? mres : rdv(rs, we, wa, wd);
        cb = (FWD && mrw && !mld && rt != 0 && md == rt) ? mres : rdv(rt, we, wa, wd);
        taken = (k == K_BEQ && ca == cb) || (k == K_BNE && ca != cb) || jmp;
        off = {{16{ins[15]}}, ins[15:0]};
        e.stall    = hold || (v && haz);
        e.redirect = v && !e.stall && taken;
        e.rpc      = jmp ? {pc4[31:28], ins[25:0], 2'b00} : pc4 + off * 4;
        if (hold) n = st;
        else if (!v || haz) n = zero_st();
        else if (k == K_BAD) begin n = zero_st(); n.ill = 1; end
        else begin
            n = zero_st();
            n.v = 1; n.pc4 = pc4; n.imm = off; n.rs = rs; n.rt = rt;
            n.rsd = rdv(rs, we, wa, wd); n.rtd = rdv(rt, we, wa, wd);
            case (k)
                K_R:    begin n.rw = 1; n.dst = ins[15:11]; n.op = 3'(r_op(ins[5:0])); end
                K_LW:   begin n.src = 1; n.mr = 1; n.rw = 1; n.m2r = 2'b01; n.dst = rt; end
                K_SW:   begin n.src = 1; n.mw = 1; n.dst = rt; end
                K_ADDI: begin n.src = 1; n.rw = 1; n.dst = rt; end
                K_SLTI: begin n.src = 1; n.rw = 1; n.dst = rt; n.op = 3'd4; end
                K_JAL:  begin n.rw = 1; n.dst = 5'd31; n.m2r = 2'b10; end
                default: ;
            endcase
        end
        e.s = n;
        q.push_back(e);
        st = n;
        if (we && wa != 0) mregs[wa] = wd;
    endtask

    task automatic dec1(input bit v, input logic [31:0] ins, input logic [31:0] pc4);
        step(v, ins, pc4, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        int rs = $urandom_range(0, 7), rt = $urandom_range(0, 7), rd = $urandom_range(0, 7);
        logic [15:0] imm = 16'($urandom);
        logic [5:0] fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
        case ($urandom_range(0, 10))
            0, 1: return mk_r(rs, rt, rd, fn[$urandom_range(0, 4)]);
            2:    return mk_r(rs, rt, rd, fn[5]);
            3:    return mk_i(6'h23, rs, rt, imm);
            4:    return mk_i(6'h2b, rs, rt, imm);
            5:    return mk_i(6'h08, rs, rt, imm);
            6:    return mk_i(6'h0a, rs, rt, imm);
            7:    return mk_i(($urandom_range(0, 1) != 0) ? 6'h04 : 6'h05, rs, rt, imm);
            8:    return {($urandom_range(0, 1) != 0) ? 6'h02 : 6'h03, 26'($urandom)};
            9:    return {6'h3f, 26'($urandom)};
            default: return mk_i(6'h04, rs, rs, imm);
        endcase
    endfunction

    // Monitor: combinational outputs sampled late in the cycle, ID/EX just after the edge.
    initial begin
        exp_t e; logic c_st, c_rd, c_fl; logic [31:0] c_pc;
        forever begin
            @(negedge clk); #4;
            if (q.size() != 0) begin
                c_st = stall; c_rd = redirect; c_fl = flush_if; c_pc = redirect_pc;
                @(posedge clk); #1;
                e = q.pop_front();
                chk("stall", c_st, e.stall);
                chk("redirect", c_rd, e.redirect);
                chk("flush_if", c_fl, e.redirect);
                if (e.redirect) chk("redirect_pc", c_pc, e.rpc);
                chk("ex_valid", ex_valid, e.s.v);
                chk("ex_illegal", ex_illegal, e.s.ill);
                chk("ex_pc4", ex_pc4, e.s.pc4);
                chk("ex_rs_data", ex_rs_data, e.s.rsd);
                chk("ex_rt_data", ex_rt_data, e.s.rtd);
                chk("ex_imm", ex_imm, e.s.imm);
                chk("ex_rs_rt_dst", {ex_rs, ex_rt, ex_dst}, {e.s.rs, e.s.rt, e.s.dst});
                chk("ex_ctrl", {ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg},
                    {e.s.op, e.s.src, e.s.mr, e.s.mw, e.s.rw, e.s.m2r});
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = 0;
        st = zero_st();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_valid", ex_valid, 0);
        chk("reset_ex_any", |{ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst, ex_alu_op,
            ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_illegal}, 0);
        @(negedge clk) rst_n = 1;

        // Write-through bypass, load-use, taken beq, jal, MEM-producer branch, illegal opcode.
        step(1, mk_r(3, 0, 4, 6'h20), 32'h10, 1, 3, 32'h1234, 0, 0, 0, 0, 0);
        dec1(1, mk_i(6'h23, 1, 2, 16'h0), 32'h14);
        dec1(1, mk_r(2, 2, 5, 6'h20), 32'h18);
        dec1(1, mk_r(2, 2, 5, 6'h20), 32'h18);
        dec1(1, mk_i(6'h04, 1, 1, 16'h4), 32'h100);
        dec1(1, {6'h03, 26'h40}, 32'h8);
        step(1, mk_i(6'h04, 7, 0, 16'h2), 32'h200, 0, 0, 0, 0, 1, 0, 7, 0);
        step(1, mk_i(6'h04, 7, 0, 16'h2), 32'h200, 1, 7, 0, 0, 0, 0, 0, 0);
        dec1(1, {6'h3f, 26'h0}, 32'h300);
        dec1(1, mk_r(0, 0, 0, 6'h20), 32'h304);
        step(1, mk_r(1, 2, 3, 6'h22), 32'h308, 0, 0, 0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) != 0, rand_instr(), 32'($urandom) & 32'hffff_fffc,
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom_range(0, 3) == 0 ? 0 : $urandom,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) != 0, $urandom_range(0, 9) < 3,
                 5'($urandom_range(0, 7)), $urandom_range(0, 3) == 0 ? 0 : $urandom);
        end
        step(0, 0, 0, 1, 5, 32'hdead, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        chk("scoreboard_drained", q.size(), 0);

        // Asynchronous reset in the middle of a cycle with a valid instruction in ID/EX.
        @(negedge clk);
        if_valid = 1; if_instr = mk_i(6'h08, 0, 1, 16'h5); if_pc4 = 32'h40;
        wb_we = 0; ex_hold = 0; mem_reg_write = 0; mem_is_load = 0;
        @(posedge clk); #1;
        chk("pre_reset_valid", ex_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("async_reset_valid", ex_valid, 0);
        chk("async_reset_dst", ex_dst, 0);
        chk("async_reset_ctrl", {ex_reg_write, ex_alu_src, ex_pc4[7:0]}, 0);
        @(negedge clk);
        rst_n = 1;
        if_instr = mk_r(5, 0, 6, 6'h20);
        @(posedge clk); #1;
        chk("post_reset_r5_valid", ex_valid, 1);
        chk("post_reset_r5_read", ex_rs_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the 5-stage pipeline; decodes one 32-bit MIPS-subset instruction per cycle.
- Owns the register file with write-through bypass, and resolves beq/bne/j/jal in ID with redirect and flush of IF/ID.
- Detects load-use and branch-operand hazards.
- Registers all decoded fields into an internal ID/EX pipeline register with a valid bit and bubble insertion.

Parameters:
XLEN, 32, datapath width of register file, operands, immediates, PC (>=32)
RADDR_W, 5, register address width; register count = 2**RADDR_W; fixed to 5 for this ISA encoding
LINK_REG, 31, destination register written by jal

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction from IF/ID
if_pc4  in  XLEN  PC+4 of that instruction
wb_we  in  1  writeback enable
wb_addr  in  RADDR_W  writeback register
wb_data  in  XLEN  writeback data
ex_hold  in  1  downstream stall; freezes ID/EX
mem_reg_write  in  1  EX/MEM instruction writes a register
mem_is_load  in  1  EX/MEM instruction is a load
mem_dst  in  RADDR_W  EX/MEM destination
mem_result  in  XLEN  EX/MEM ALU result
stall  out  1  hold PC and IF/ID (combinational)
flush_if  out  1  kill IF/ID content next edge (combinational)
redirect  out  1  PC must load redirect_pc (combinational)
redirect_pc  out  XLEN  branch/jump target
ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst  out  1/XLEN/XLEN/XLEN/XLEN/RADDR_W/RADDR_W/RADDR_W  registered ID/EX fields
ex_alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write  out  1 each  registered controls
ex_mem_to_reg  out  2  00 ALU, 01 memory, 10 pc4
ex_illegal  out  1  registered pulse: undecodable opcode/funct accepted

Behaviour:
- Reset: all ID/EX outputs 0; all registers 0.
- Register file: register 0 reads 0 and ignores writes. Written on posedge when wb_we. A read of wb_addr while wb_we returns wb_data in the same cycle (write-through bypass).
- Decode:
  - R-type (opc 0): funct 100000/100010/100100/100101/101010 map to add/sub/and/or/slt; dst = rd.
  - lw 100011, sw 101011, addi 001000, slti 001010: immediate sign-extended to XLEN, alu_src=1, dst = rt.
  - beq 000100, bne 000101, j 000010, jal 000011.
  - Any other opc/funct: enters ID/EX as a bubble with ex_illegal=1 for one accepted cycle.
- Load-use hazard: ex_valid & ex_mem_read & ex_dst!=0 & ex_dst matches a source actually used (rs always except j/jal; rt for R-type, sw, beq, bne).
- Branch-operand hazard (beq/bne only):
  - ID/EX producer (ex_reg_write, ex_dst!=0, matches rs or rt) -> hazard.
  - MEM producer with mem_is_load -> hazard.
  - Other MEM producer handling depends on the optional feature.
- stall = if_valid & hazard, OR ex_hold.
- Targets:
  - Branch taken: beq & equal, or bne & !equal; redirect_pc = if_pc4 + (imm<<2).
  - j/jal: redirect_pc = {if_pc4[XLEN-1:28], instr[25:0], 2'b00}.
- redirect and flush_if assert only when the taken branch or jump is accepted (if_valid & !stall); both are low during any stall.
- ID/EX update on posedge:
  - ex_hold: all fields hold.
  - else hazard, or !if_valid: bubble (ex_valid=0, all controls 0).
  - else decoded instruction, ex_valid=1.
- beq/bne/j enter as ex_valid=1 with all controls 0. jal enters with reg_write=1, dst=LINK_REG, mem_to_reg=10.
- Reset asserted mid-operation clears ID/EX immediately (asynchronous); register contents also clear.

Optional Feature:
BRANCH_FWD_EN
- Defined: a non-load MEM producer matching a beq/bne source forwards mem_result into the comparator; no stall.
- Undefined: that case stalls for one cycle until the producer reaches WB and is covered by the write-through bypass. mem_result is unused.

Test Plan:
- Reset low mid-stream -> all ex_* outputs 0 the same cycle; reading r5 after release returns 0.
- wb_we=1, wb_addr=3, wb_data=0x1234 while decoding add r4,r3,r0 -> ex_rs_data=0x1234 next edge.
- lw r2,0(r1) followed by add r5,r2,r2 -> stall=1 for 1 cycle, one bubble (ex_valid=0), then add issues.
- beq r1,r1,+4 with if_pc4=0x100 -> redirect=1, redirect_pc=0x110, flush_if=1.
- jal 0x40 with if_pc4=0x8 -> redirect_pc=0x100; next edge ex_dst=31, ex_mem_to_reg=10, ex_pc4=0x8.
- add r7,… in MEM then beq r7,r0 -> stall 0 cycles with BRANCH_FWD_EN, 1 cycle without. Opcode 111111 -> ex_illegal pulses once, ex_valid=0.
